mux_n_arb: RTL and testbench
============================

# mux_n_arb

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. It generalises the combinational 2:1 mux. It adds a one-entry output register, per-channel flow control, and a choice of fixed-select or round-robin channel selection. It sits between several producer streams and a single consumer, and delivers one word per cycle at full throughput.

## Interface
- WIDTH, 8, data width per channel (≥1)
- N, 4, number of input channels (≥2; need not be a power of two)
- MODE, 0, 0 = fixed select via `s`; 1 = round-robin among valid channels (`s` ignored)
- SW, $clog2(N), select/channel-index width (derived; not overridden)

Ports:
- clk  input  1  sole clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N  channel k offers a word
- in_ready  output  N  channel k word is accepted this cycle (combinational)
- s  input  SW  channel select, used in MODE 0 only
- out  output  WIDTH  registered output word
- out_ch  output  SW  index of the channel that supplied `out`
- out_valid  output  1  `out` holds an undelivered word
- out_ready  input  1  consumer accepts `out` this cycle

## Operation
- Reset (async assert, whenever rst_n=0): out=0, out_ch=0, out_valid=0, round-robin pointer ptr=0. All outputs are also 0 after release until the first load.
- Slot free: `free = !out_valid || out_ready`.
- Grant, MODE 0: g=s when s<N and in_valid[s]=1. Otherwise there is no grant, and this includes s≥N.
- Grant, MODE 1: g is the first k with in_valid[k]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. There is no grant if in_valid==0.
- Load: when free and a grant exists:
  - in_ready[g]=1 and all other in_ready bits are 0.
  - At the clock edge: out←in_data[g], out_ch←g, out_valid←1.
  - MODE 1 only: ptr←(g==N-1) ? 0 : g+1.
- in_ready is all-zero when no load occurs. in_ready[k] never asserts unless in_valid[k]=1.
- Drain without load: when out_valid and out_ready and there is no grant, out_valid←0. out and out_ch keep their last value.
- Stall: when out_valid=1 and out_ready=0, out, out_ch and out_valid hold. All in_ready bits are 0.
- Simultaneous drain and load (out_valid, out_ready and a grant): the old word is delivered and the new word is loaded on the same edge. out_valid stays 1.
- ptr is unchanged in MODE 0 and whenever no load occurs.
- Every accepted input word appears on `out` exactly once, in acceptance order. No word is duplicated or dropped.

## Timing
- Latency is 1 cycle: a word accepted at edge t is visible on out/out_valid after edge t.
- Throughput is 1 word per cycle while out_ready=1 and a grant exists.
- in_ready is combinational from in_valid, s, out_valid, out_ready and ptr. There is no combinational path from in_data to any output.
- Changing `s` while a word sits stalled in the output register has no effect on that word. The new `s` applies only to the next load.
- Reset asserted mid-transfer: out_valid drops immediately (asynchronously) and the held word is discarded. On the first edge after release, the block may load if a grant exists.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive loads.

## Test plan
- Reset: drive in_valid=4'b1111 and out_ready=1, pulse rst_n low between edges → out=0, out_valid=0 and out_ch=0 immediately. After release, the first load in MODE 1 is channel 0.
- MODE 0 select walk (N=4, WIDTH=8): in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, all valid, out_ready=1, s = 0, 1, 2, 3 on successive cycles → out = A0, B1, C2, D3 one cycle later, with out_ch = 0..3 and in_ready one-hot following s.
- MODE 0 invalid select (N=3): set s=3, all valid → in_ready=0 and out_valid falls to 0 after the pending word drains.
- Backpressure: load 8'h5A, then hold out_ready=0 for 3 cycles while changing s and in_data → out=5A and out_valid=1 stay stable, and in_ready=0. Raise out_ready → 5A is delivered and the next word is loaded on the same edge.
- MODE 1 fairness: all channels valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3.
- MODE 1 skip: only in_valid[1] and in_valid[3] set, starting from ptr=2 → grant order 3,1,3,1. in_ready[0] and in_ready[2] stay 0.

Source files
------------

// File: rtl/mux_n_arb.sv
// mux_n_arb: N-channel registered mux with valid/ready handshakes.
// Channel selection is either fixed by s (MODE 0) or round-robin among valid inputs (MODE 1).
module mux_n_arb #(
    parameter int WIDTH = 8,
    parameter int N = 4,
    parameter int MODE = 0,
    localparam int SW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      s,
    output logic [WIDTH-1:0]   out,
    output logic [SW-1:0]      out_ch,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam logic [SW:0]   NL = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [SW-1:0]    ch_q, ch_d, ptr_q, ptr_d, g;
    logic [SW:0]      idx;
    logic             valid_q, valid_d, gnt, load;

    // Round-robin scan runs from lowest to highest priority so the nearest valid channel after ptr wins.
    always_comb begin
        gnt = 1'b0;
        g = '0;
        idx = '0;
        if (MODE == 0) begin
            gnt = ({1'b0, s} < NL) && in_valid[s];
            g = s;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                idx = {1'b0, ptr_q} + (SW + 1)'(i);
                idx = (idx >= NL) ? idx - NL : idx;
                if (in_valid[idx[SW-1:0]]) begin
                    gnt = 1'b1;
                    g = idx[SW-1:0];
                end
            end
        end
    end

    assign load = (!valid_q || out_ready) && gnt;
    assign in_ready = load ? N'(1) << g : '0;

    always_comb begin
        out_d = load ? in_data[g*WIDTH +: WIDTH] : out_q;
        ch_d = load ? g : ch_q;
        valid_d = load || (valid_q && !out_ready);
        ptr_d = (load && MODE == 1) ? ((g == LAST) ? '0 : g + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ch_q <= '0;
            ptr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ch_q <= ch_d;
            ptr_q <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign out = out_q;
    assign out_ch = ch_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_n_arb.sv
// tb_mux_n_arb: checks three mux_n_arb instances (N=4 fixed, N=3 fixed, N=4 round-robin)
// with directed scenarios and randomized traffic against a queue-based reference model.
module tb_mux_n_arb;
    localparam int NN[3] = '{4, 3, 4};
    localparam int MD[3] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0][31:0] in_data;
    logic [2:0][3:0]  in_valid;
    wire  [2:0][3:0]  in_ready;
    logic [2:0][1:0]  s;
    wire  [2:0][7:0]  out;
    wire  [2:0][1:0]  out_ch;
    wire  [2:0]       out_valid;
    logic [2:0]       out_ready;

    int checks = 0;
    int errors = 0;

    logic [2:0][7:0] m_out;
    logic [2:0][1:0] m_ch;
    logic [2:0]      m_val;
    int              m_ptr[3];
    logic [7:0]      sbq[$];

    always #5 clk = ~clk;

    mux_n_arb #(.WIDTH(8), .N(4), .MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .s(s[0]), .out(out[0]), .out_ch(out_ch[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]));

    mux_n_arb #(.WIDTH(8), .N(3), .MODE(0)) d1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1][23:0]), .in_valid(in_valid[1][2:0]),
        .in_ready(in_ready[1][2:0]), .s(s[1]), .out(out[1]), .out_ch(out_ch[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]));
    assign in_ready[1][3] = 1'b0;

    mux_n_arb #(.WIDTH(8), .N(4), .MODE(1)) d2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .s(s[2]), .out(out[2]), .out_ch(out_ch[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]));

    // Reference grant: -1 when nothing can be granted.
    function automatic int model_gnt(int d);
        if (MD[d] == 0)
            return (int'(s[d]) < NN[d] && in_valid[d][s[d]]) ? int'(s[d]) : -1;
        for (int i = 0; i < NN[d]; i++)
            if (in_valid[d][(m_ptr[d] + i) % NN[d]]) return (m_ptr[d] + i) % NN[d];
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(int d);
        int g = model_gnt(d);
        return ((!m_val[d] || out_ready[d]) && g >= 0) ? 4'(1) << g : 4'(0);
    endfunction

    task automatic model_edge(int d);
        int g = model_gnt(d);
        if ((!m_val[d] || out_ready[d]) && g >= 0) begin
            m_out[d] = in_data[d][g*8 +: 8];
            m_ch[d] = 2'(g);
            m_val[d] = 1'b1;
            m_ptr[d] = (g + 1) % NN[d];
            sbq.push_back(m_out[d]);
        end else if (out_ready[d]) begin
            m_val[d] = 1'b0;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        in_data = '0;
        in_valid = '0;
        s = '0;
        out_ready = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        m_out = '0;
        m_ch = '0;
        m_val = '0;
        m_ptr = '{0, 0, 0};
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({out_valid[d], out_ch[d], out[d]} !== 11'h0) begin
                errors++;
                $display("FAIL reset_init d%0d: got v=%b ch=%0d out=%h want all zero", d, out_valid[d], out_ch[d], out[d]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_data[2] = 32'h44332211;
        in_valid[2] = 4'hF;
        out_ready[2] = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid[2], out_ch[2], out[2]} !== {1'b1, 2'd1, 8'h22}) begin
            errors++;
            $display("FAIL reset_preload: got v=%b ch=%0d out=%h want v=1 ch=1 out=22", out_valid[2], out_ch[2], out[2]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid[2], out_ch[2], out[2]} !== 11'h0) begin
            errors++;
            $display("FAIL reset_async: got v=%b ch=%0d out=%h want all zero", out_valid[2], out_ch[2], out[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out_valid[2], out_ch[2], out[2]} !== {1'b1, 2'd0, 8'h11}) begin
            errors++;
            $display("FAIL reset_first_rr: got v=%b ch=%0d out=%h want v=1 ch=0 out=11", out_valid[2], out_ch[2], out[2]);
        end
    endtask

    task automatic test_select_walk;
        logic [7:0] walk[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        do_reset();
        in_data[0] = 32'hD3C2B1A0;
        in_valid[0] = 4'hF;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s[0] = 2'(i);
            #1;
            checks++;
            if (in_ready[0] !== 4'(1 << i)) begin
                errors++;
                $display("FAIL walk_rdy s=%0d: got %b want %b", i, in_ready[0], 4'(1 << i));
            end
            tick();
            checks++;
            if ({out_valid[0], out_ch[0], out[0]} !== {1'b1, 2'(i), walk[i]}) begin
                errors++;
                $display("FAIL walk_out s=%0d: got v=%b ch=%0d out=%h want v=1 ch=%0d out=%h", i, out_valid[0], out_ch[0], out[0], i, walk[i]);
            end
        end
    endtask

    task automatic test_invalid_select;
        do_reset();
        in_data[1] = 32'h00332211;
        in_valid[1] = 4'h7;
        out_ready[1] = 1'b1;
        s[1] = 2'd1;
        tick();
        checks++;
        if ({out_valid[1], out_ch[1], out[1]} !== {1'b1, 2'd1, 8'h22}) begin
            errors++;
            $display("FAIL badsel_load: got v=%b ch=%0d out=%h want v=1 ch=1 out=22", out_valid[1], out_ch[1], out[1]);
        end
        s[1] = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (in_ready[1] !== 4'h0) begin
                errors++;
                $display("FAIL badsel_rdy %0d: got %b want 0000", i, in_ready[1]);
            end
            tick();
            checks++;
            if ({out_valid[1], out_ch[1], out[1]} !== {1'b0, 2'd1, 8'h22}) begin
                errors++;
                $display("FAIL badsel_drain %0d: got v=%b ch=%0d out=%h want v=0 ch=1 out=22", i, out_valid[1], out_ch[1], out[1]);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        in_data[0] = 32'h005A0000;
        in_valid[0] = 4'hF;
        s[0] = 2'd2;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s[0] = 2'($urandom);
            in_data[0] = $urandom;
            #1;
            checks++;
            if (in_ready[0] !== 4'h0) begin
                errors++;
                $display("FAIL stall_rdy %0d: got %b want 0000", i, in_ready[0]);
            end
            tick();
            checks++;
            if ({out_valid[0], out_ch[0], out[0]} !== {1'b1, 2'd2, 8'h5A}) begin
                errors++;
                $display("FAIL stall_hold %0d: got v=%b ch=%0d out=%h want v=1 ch=2 out=5a", i, out_valid[0], out_ch[0], out[0]);
            end
        end
        out_ready[0] = 1'b1;
        s[0] = 2'd1;
        in_data[0][15:8] = 8'h77;
        #1;
        checks++;
        if (in_ready[0] !== 4'b0010) begin
            errors++;
            $display("FAIL release_rdy: got %b want 0010", in_ready[0]);
        end
        tick();
        checks++;
        if ({out_valid[0], out_ch[0], out[0]} !== {1'b1, 2'd1, 8'h77}) begin
            errors++;
            $display("FAIL release_load: got v=%b ch=%0d out=%h want v=1 ch=1 out=77", out_valid[0], out_ch[0], out[0]);
        end
    endtask

    task automatic test_rr_fairness;
        logic [31:0] data = 32'h44332211;
        do_reset();
        in_data[2] = data;
        in_valid[2] = 4'hF;
        out_ready[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (in_ready[2] !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rr_rdy %0d: got %b want %b", i, in_ready[2], 4'(1 << (i % 4)));
            end
            tick();
            checks++;
            if ({out_valid[2], out_ch[2], out[2]} !== {1'b1, 2'(i % 4), data[(i % 4)*8 +: 8]}) begin
                errors++;
                $display("FAIL rr_seq %0d: got v=%b ch=%0d out=%h want ch=%0d", i, out_valid[2], out_ch[2], out[2], i % 4);
            end
        end
    endtask

    task automatic test_rr_skip;
        int exp_ch;
        do_reset();
        in_data[2] = 32'hDDCCBBAA;
        in_valid[2] = 4'b0010;
        out_ready[2] = 1'b1;
        tick();
        in_valid[2] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 0) ? 3 : 1;
            #1;
            checks++;
            if (in_ready[2] !== 4'(1 << exp_ch)) begin
                errors++;
                $display("FAIL skip_rdy %0d: got %b want %b", i, in_ready[2], 4'(1 << exp_ch));
            end
            tick();
            checks++;
            if (out_ch[2] !== 2'(exp_ch) || out_valid[2] !== 1'b1) begin
                errors++;
                $display("FAIL skip_ch %0d: got ch=%0d v=%b want ch=%0d v=1", i, out_ch[2], out_valid[2], exp_ch);
            end
        end
    endtask

    task automatic test_random(int d);
        logic [7:0] w;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid[d] = 4'($urandom);
            s[d] = 2'($urandom);
            in_data[d] = $urandom;
            out_ready[d] = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready[d] !== exp_rdy(d)) begin
                errors++;
                $display("FAIL rand%0d_rdy cyc %0d: got %b want %b", d, c, in_ready[d], exp_rdy(d));
            end
            if (m_val[d] && out_ready[d]) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rand%0d_order cyc %0d: got %h want none delivered", d, c, out[d]);
                end else begin
                    w = sbq.pop_front();
                    if (out[d] !== w) begin
                        errors++;
                        $display("FAIL rand%0d_order cyc %0d: got %h want %h", d, c, out[d], w);
                    end
                end
            end
            model_edge(d);
            tick();
            checks++;
            if ({out_valid[d], out_ch[d], out[d]} !== {m_val[d], m_ch[d], m_out[d]}) begin
                errors++;
                $display("FAIL rand%0d_out cyc %0d: got v=%b ch=%0d out=%h want v=%b ch=%0d out=%h",
                         d, c, out_valid[d], out_ch[d], out[d], m_val[d], m_ch[d], m_out[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_select_walk();
        test_invalid_select();
        test_backpressure();
        test_rr_fairness();
        test_rr_skip();
        test_random(0);
        test_random(1);
        test_random(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
